// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the NAND-counter sequencer: one-hot state encoding,
// state bit positions and the counter feedback width.
package counter_ctrl_pkg;

    localparam int Q_W = 2;

    // Bit positions inside the one-hot state vector
    localparam int S_IDLE   = 0;
    localparam int S_CLEAR  = 1;
    localparam int S_TICK   = 2;
    localparam int S_SETTLE = 3;
    localparam int S_CHECK  = 4;
    localparam int S_DONE   = 5;
    localparam int N_STATES = 6;

    typedef enum logic [N_STATES-1:0] {
        IDLE   = 6'b000001,
        CLEAR  = 6'b000010,
        TICK   = 6'b000100,
        SETTLE = 6'b001000,
        CHECK  = 6'b010000,
        DONE   = 6'b100000
    } state_e;

    // Next value of a free-running 2-bit count (wraps 3 -> 0)
    function automatic logic [Q_W-1:0] q_next(input logic [Q_W-1:0] q);
        return q + 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Loadable down-counter with a zero flag. Used for both the CLEAR hold time
// and the SETTLE window; it stops at zero until reloaded.
module ctrl_wait_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the gate-level 2-bit NAND counter: clears it, issues clean
// tick pulses, waits for the ripple to settle and checks the count after
// every tick. Reports done, aborted, sticky mismatch and the wrap count.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int RUN_W      = 8,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] run_len,
    input  logic             abort,
    input  logic [Q_W-1:0]   q,
    output logic             cnt_reset_n,
    output logic             cnt_tick,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             mismatch,
    output logic [RUN_W-1:0] wrap_cnt,
    output logic [Q_W-1:0]   exp_q
);

    localparam int MAX_CYC = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e           r_state;
    logic [RUN_W-1:0] r_rem;
    logic [RUN_W-1:0] r_wrap;
    logic [Q_W-1:0]   r_exp;
    logic             r_aborted;
    logic             r_mismatch;

    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic [Q_W-1:0]   w_exp_next;
    logic             w_in_run;

    // Saturating increment for the wrap counter
    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The timer is (re)loaded on the cycle before CLEAR or SETTLE is entered
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TMR_W'(SETTLE_CYC - 1);
        if (r_state == IDLE) begin
            w_tmr_load = start && (run_len != '0);
            w_tmr_val  = TMR_W'(CLR_CYC - 1);
        end else if (r_state == TICK) begin
            w_tmr_load = !abort;
        end
    end

    ctrl_wait_timer #(
        .W(TMR_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    assign w_exp_next = q_next(r_exp);
    assign w_in_run   = r_state[S_CLEAR] | r_state[S_TICK] | r_state[S_SETTLE] | r_state[S_CHECK];

    // Main sequencing FSM with the run bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_wrap     <= '0;
            r_exp      <= '0;
            r_aborted  <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (w_in_run && abort) begin
            // Abort pre-empts every in-run state, including the CHECK update
            r_state   <= DONE;
            r_aborted <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem      <= run_len;
                        r_wrap     <= '0;
                        r_exp      <= '0;
                        r_aborted  <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_state    <= (run_len != '0) ? CLEAR : DONE;
                    end
                end
                CLEAR: begin
                    if (w_tmr_zero) r_state <= TICK;
                end
                TICK: begin
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (w_tmr_zero) r_state <= CHECK;
                end
                CHECK: begin
                    if (q != w_exp_next) r_mismatch <= 1'b1;
                    r_exp <= w_exp_next;
                    if (w_exp_next == '0) r_wrap <= sat_inc(r_wrap);
                    r_rem   <= r_rem - 1'b1;
                    r_state <= (r_rem == RUN_W'(1)) ? DONE : TICK;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore decodes of single state bits keep cnt_tick and cnt_reset_n glitch-free
    assign cnt_reset_n = ~r_state[S_CLEAR];
    assign cnt_tick    = r_state[S_TICK];
    assign done        = r_state[S_DONE];
    assign busy        = ~r_state[S_IDLE];
    assign aborted     = r_aborted;
    assign mismatch    = r_mismatch;
    assign wrap_cnt    = r_wrap;
    assign exp_q       = r_exp;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a behavioural 2-bit counter on cnt_tick /
// cnt_reset_n feeds q back, and each run's outcome is predicted from the
// run length, abort cycle and counter fault mode with plain arithmetic.
module tb_counter_seq_ctrl;

    localparam int RUN_W      = 8;
    localparam int CLR_CYC    = 2;
    localparam int SETTLE_CYC = 3;
    localparam int PERIOD     = SETTLE_CYC + 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [RUN_W-1:0] run_len;
    logic             abort;
    logic [1:0]       q;
    logic             cnt_reset_n;
    logic             cnt_tick;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             mismatch;
    logic [RUN_W-1:0] wrap_cnt;
    logic [1:0]       exp_q;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural NAND counter: async active-low clear, advances on tick rise
    logic [1:0] m_cnt;
    bit         m_stuck;

    always @(negedge cnt_reset_n or posedge cnt_tick) begin
        if (!cnt_reset_n) m_cnt <= 2'd0;
        else              m_cnt <= m_cnt + 2'd1;
    end

    assign q = m_stuck ? 2'd0 : m_cnt;

    always #5 clock = ~clock;

    counter_seq_ctrl #(
        .RUN_W      (RUN_W),
        .CLR_CYC    (CLR_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .run_len     (run_len),
        .abort       (abort),
        .q           (q),
        .cnt_reset_n (cnt_reset_n),
        .cnt_tick    (cnt_tick),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .mismatch    (mismatch),
        .wrap_cnt    (wrap_cnt),
        .exp_q       (exp_q)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_rstn"},  int'(cnt_reset_n), 1);
        check_val({tag, "_tick"},  int'(cnt_tick), 0);
        check_val({tag, "_busy"},  int'(busy), 0);
        check_val({tag, "_done"},  int'(done), 0);
        check_val({tag, "_abrt"},  int'(aborted), 0);
        check_val({tag, "_mism"},  int'(mismatch), 0);
        check_val({tag, "_wrap"},  int'(wrap_cnt), 0);
        check_val({tag, "_expq"},  int'(exp_q), 0);
    endtask

    // One run. abort_k: cycle (1 = first cycle after the start edge) in which
    // abort is held high, 0 = never. busy_start_c: cycle with a stray start.
    task automatic run(input string tag, input int len, input int abort_k,
                       input bit stuck, input int busy_start_c, input bit abort_at_start);
        int full_lat, lat, checks, ticks, clr, ab;
        int c, done_c, tick_cnt, clr_cnt, first_mm;
        int exp_wrap;

        // ---- reference prediction ----
        full_lat = (len == 0) ? 1 : CLR_CYC + len * PERIOD + 1;
        ab = (len != 0 && abort_k > 0 && abort_k < full_lat) ? 1 : 0;
        if (ab != 0) begin
            lat = abort_k + 1;
            if (abort_k <= CLR_CYC) begin
                checks = 0; ticks = 0; clr = abort_k;
            end else begin
                checks = (abort_k - CLR_CYC - 1) / PERIOD;
                ticks  = checks + 1;
                clr    = CLR_CYC;
            end
        end else begin
            lat    = full_lat;
            checks = len;
            ticks  = len;
            clr    = (len != 0) ? CLR_CYC : 0;
        end
        exp_wrap = checks / 4;
        if (exp_wrap > 255) exp_wrap = 255;

        // ---- stimulus and observation ----
        m_stuck = stuck;
        @(negedge clock);
        start   = 1'b1;
        run_len = RUN_W'(len);
        abort   = abort_at_start;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        done_c = -1; tick_cnt = 0; clr_cnt = 0; first_mm = -1;
        c = 1;
        while (c <= full_lat + 8) begin
            if (cnt_tick) begin
                check_val({tag, "_tickpos"}, c, CLR_CYC + 1 + tick_cnt * PERIOD);
                tick_cnt++;
            end
            if (!cnt_reset_n) clr_cnt++;
            if (mismatch && first_mm < 0) first_mm = c;
            if (done) begin
                done_c = c;
                break;
            end
            abort   = (c == abort_k);
            start   = (c == busy_start_c);
            run_len = RUN_W'($urandom);
            @(negedge clock);
            c++;
        end
        abort = 1'b0;
        start = 1'b0;

        check_val({tag, "_latency"}, done_c, lat);
        check_val({tag, "_ticks"},   tick_cnt, ticks);
        check_val({tag, "_clrcyc"},  clr_cnt, clr);
        check_val({tag, "_expq"},    int'(exp_q), checks % 4);
        check_val({tag, "_wrap"},    int'(wrap_cnt), exp_wrap);
        check_val({tag, "_abrt"},    int'(aborted), ab);
        check_val({tag, "_mism"},    int'(mismatch), (stuck && checks >= 1) ? 1 : 0);
        // A stuck counter fails the first compare, visible the cycle after it
        if (stuck && checks >= 1)
            check_val({tag, "_mm_first"}, first_mm, CLR_CYC + PERIOD + 1);
        @(negedge clock);
        check_val({tag, "_idle_after"}, int'(busy), 0);
        check_val({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int len, ak, fl;
        bit st;

        reset = 1'b1; start = 1'b0; abort = 1'b0; run_len = '0;
        m_stuck = 1'b0;
        m_cnt = 2'($urandom);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("reset");
        reset = 1'b0;

        run("t1_len5", 5, 0, 1'b0, 0, 1'b0);
        run("t2_len0", 0, 0, 1'b0, 0, 1'b0);
        run("t3_stuck", 3, 0, 1'b1, 0, 1'b0);
        run("t4_abort", 4, 10, 1'b0, 0, 1'b0);
        run("t4_after", 2, 0, 1'b0, 0, 1'b0);
        run("t5_busystart", 3, 0, 1'b0, 5, 1'b0);
        run("t5_startabort", 2, 0, 1'b0, 0, 1'b1);
        run("abort_clear", 6, 1, 1'b0, 0, 1'b0);
        run("abort_check", 3, CLR_CYC + PERIOD, 1'b1, 0, 1'b0);
        run("len4_wrap", 4, 0, 1'b0, 0, 1'b0);

        // Reset in the middle of SETTLE of a running sequence
        @(negedge clock);
        start = 1'b1; run_len = 8'd4;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("t6_midrst");
        reset = 1'b0;
        run("t6_len255", 255, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(0, 14);
            st  = ($urandom_range(0, 3) == 0);
            fl  = (len == 0) ? 1 : CLR_CYC + len * PERIOD + 1;
            ak  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, fl + 2) : 0;
            run($sformatf("rnd%0d", i), len, ak, st, $urandom_range(0, fl + 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
